// File: rtl/div_pkg.sv
// Shared encodings for the sequential restoring divider.
// State values are fixed so that waveforms and debug tools can decode them.
package div_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/seq_restoring_divider_if.sv
// Start/done request bundle between an issuing unit (master) and the divider (slave).
// One request is in flight at a time; a start is taken only while the divider is idle.
interface seq_restoring_divider_if #(
    parameter int BUS_WIDTH = 32
);

    logic                 start;
    logic [BUS_WIDTH-1:0] dividend;
    logic [BUS_WIDTH-1:0] divisor;
    logic                 busy;
    logic                 done;
    logic [BUS_WIDTH-1:0] quotient;
    logic [BUS_WIDTH-1:0] remainder;
    logic                 div_by_zero;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero
    );

endinterface

// File: rtl/seq_restoring_divider_adder.sv
// Ripple-carry adder/subtractor: out = a + b, or a - b when add_sub_b is high.
// Purely combinational, no flow control; ovf flags signed overflow of the result.
module ripple_carry_adder #(
    parameter int BUS_WIDTH = 8
) (
    input  logic [BUS_WIDTH-1:0] a,
    input  logic [BUS_WIDTH-1:0] b,
    input  logic                 add_sub_b,
    output logic [BUS_WIDTH-1:0] out,
    output logic                 ovf
);

    logic [BUS_WIDTH-1:0] b_eff;
    logic [BUS_WIDTH:0]   carry;

    always_comb begin
        b_eff    = b ^ {BUS_WIDTH{add_sub_b}};
        carry    = '0;
        carry[0] = add_sub_b;
        out      = '0;
        for (int i = 0; i < BUS_WIDTH; i++) begin
            out[i]       = a[i] ^ b_eff[i] ^ carry[i];
            carry[i + 1] = (a[i] & b_eff[i]) | (carry[i] & (a[i] ^ b_eff[i]));
        end
        ovf = carry[BUS_WIDTH] ^ carry[BUS_WIDTH - 1];
    end

endmodule

// File: rtl/seq_restoring_divider.sv
// Unsigned restoring divider, one quotient bit per cycle: done BUS_WIDTH+1 cycles after accept
// (1 cycle for divide-by-zero); start is ignored unless idle, results held until the next accept.
module seq_restoring_divider
    import div_pkg::*;
#(
    parameter int BUS_WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    seq_restoring_divider_if.slave bus
);

    localparam int CNT_W = $clog2(BUS_WIDTH + 1);
    localparam int AW    = BUS_WIDTH + 2;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [BUS_WIDTH-1:0] p_q, p_d;
    logic [BUS_WIDTH-1:0] q_q, q_d;
    logic [BUS_WIDTH-1:0] dvs_q, dvs_d;
    logic [BUS_WIDTH-1:0] quo_q, quo_d;
    logic [BUS_WIDTH-1:0] rem_q, rem_d;
    logic                 dbz_q, dbz_d;

    logic [BUS_WIDTH:0]   trial_s;
    logic [AW-1:0]        add_a, add_b, diff;
    logic                 trial_neg;
    logic [BUS_WIDTH-1:0] step_p, step_q;
    logic                 diff_msb_unused;
    logic                 adder_ovf_unused;

    // Two spare bits keep {P, Q[MSB]} - divisor from wrapping even for all-ones operands.
    assign trial_s = {p_q, q_q[BUS_WIDTH-1]};
    assign add_a   = {1'b0, trial_s};
    assign add_b   = {2'b00, dvs_q};

    ripple_carry_adder #(.BUS_WIDTH(AW)) u_trial_sub (
        .a         (add_a),
        .b         (add_b),
        .add_sub_b (1'b1),
        .out       (diff),
        .ovf       (adder_ovf_unused)
    );

    assign trial_neg       = diff[AW-1];
    assign diff_msb_unused = diff[BUS_WIDTH];
    assign step_p          = trial_neg ? trial_s[BUS_WIDTH-1:0] : diff[BUS_WIDTH-1:0];
    assign step_q          = {q_q[BUS_WIDTH-2:0], ~trial_neg};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        p_d     = p_q;
        q_d     = q_q;
        dvs_d   = dvs_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        dbz_d   = dbz_q;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    if (bus.divisor == '0) begin
                        state_d = ST_DONE;
                        quo_d   = '1;
                        rem_d   = bus.dividend;
                        dbz_d   = 1'b1;
                    end else begin
                        state_d = ST_RUN;
                        cnt_d   = CNT_W'(BUS_WIDTH);
                        p_d     = '0;
                        q_d     = bus.dividend;
                        dvs_d   = bus.divisor;
                    end
                end
            end
            ST_RUN: begin
                p_d   = step_p;
                q_d   = step_q;
                cnt_d = cnt_q - CNT_W'(1);
                // Visible results only change on the final step.
                if (cnt_q == CNT_W'(1)) begin
                    state_d = ST_DONE;
                    quo_d   = step_q;
                    rem_d   = step_p;
                    dbz_d   = 1'b0;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            p_q     <= '0;
            q_q     <= '0;
            dvs_q   <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            p_q     <= p_d;
            q_q     <= q_d;
            dvs_q   <= dvs_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            dbz_q   <= dbz_d;
        end
    end

    assign bus.busy        = (state_q == ST_RUN);
    assign bus.done        = (state_q == ST_DONE);
    assign bus.quotient    = quo_q;
    assign bus.remainder   = rem_q;
    assign bus.div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Bench for seq_restoring_divider: 32-bit vector table and corner sequences, then 8-bit random run.
module tb_seq_restoring_divider;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] q;
        logic [31:0] r;
        logic        z;
    } vec_t;

    typedef struct {
        logic [31:0] q;
        logic [31:0] r;
        logic        z;
        int          lat;
    } exp_t;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_fail;

    exp_t sb32[$];
    exp_t sb8[$];
    logic [31:0] last_q32, last_r32;
    logic [7:0]  last_q8, last_r8;

    seq_restoring_divider_if #(.BUS_WIDTH(32)) bus32 ();
    seq_restoring_divider_if #(.BUS_WIDTH(8))  bus8 ();

    seq_restoring_divider #(.BUS_WIDTH(32)) dut32 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus32.slave)
    );

    seq_restoring_divider #(.BUS_WIDTH(8)) dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus8.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Called at the negedge after the accept edge; waits for done and checks the result.
    task automatic wait_check32(input string tag);
        int   lat, busy_cnt;
        logic held_ok;
        exp_t e;
        lat      = 1;
        busy_cnt = 0;
        held_ok  = 1'b1;
        while (!bus32.done && lat < 60) begin
            if (bus32.busy) busy_cnt++;
            if (bus32.quotient !== last_q32 || bus32.remainder !== last_r32) held_ok = 1'b0;
            bus32.dividend = $urandom;
            bus32.divisor  = $urandom;
            @(negedge clk);
            lat++;
        end
        e = sb32.pop_front();
        check({tag, "_done_seen"}, 64'(bus32.done), 64'd1);
        check({tag, "_latency"}, 64'(lat), 64'(e.lat));
        check({tag, "_busy_cycles"}, 64'(busy_cnt), 64'(e.lat - 1));
        check({tag, "_held"}, 64'(held_ok), 64'd1);
        check({tag, "_busy_at_done"}, 64'(bus32.busy), 64'd0);
        check({tag, "_q"}, 64'(bus32.quotient), 64'(e.q));
        check({tag, "_r"}, 64'(bus32.remainder), 64'(e.r));
        check({tag, "_dbz"}, 64'(bus32.div_by_zero), 64'(e.z));
        last_q32 = e.q;
        last_r32 = e.r;
        @(negedge clk);
        check({tag, "_done_pulse"}, 64'(bus32.done), 64'd0);
        check({tag, "_idle_busy"}, 64'(bus32.busy), 64'd0);
    endtask

    task automatic op32(input vec_t v, input string tag);
        exp_t e;
        e.q   = v.q;
        e.r   = v.r;
        e.z   = v.z;
        e.lat = (v.b == 32'd0) ? 1 : 33;
        bus32.start    = 1'b1;
        bus32.dividend = v.a;
        bus32.divisor  = v.b;
        sb32.push_back(e);
        @(negedge clk);
        bus32.start = 1'b0;
        wait_check32(tag);
    endtask

    vec_t vecs[9];

    initial begin
        vec_t v;
        exp_t e;
        int   lat, done_cnt, a8, b8, gap;
        logic held_ok;

        vecs[0] = '{32'd100,        32'd7,          32'd14,         32'd2,      1'b0};
        vecs[1] = '{32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  32'd0,      1'b0};
        vecs[2] = '{32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'd1,          32'd0,      1'b0};
        vecs[3] = '{32'd5,          32'd9,          32'd0,          32'd5,      1'b0};
        vecs[4] = '{32'd1234,       32'd0,          32'hFFFF_FFFF,  32'd1234,   1'b1};
        vecs[5] = '{32'd0,          32'd7,          32'd0,          32'd0,      1'b0};
        vecs[6] = '{32'h8000_0000,  32'd3,          32'h2AAA_AAAA,  32'd2,      1'b0};
        vecs[7] = '{32'hDEAD_BEEF,  32'h0001_0000,  32'h0000_DEAD,  32'hBEEF,   1'b0};
        vecs[8] = '{32'd7,          32'd0,          32'hFFFF_FFFF,  32'd7,      1'b1};

        n_cmp          = 0;
        n_fail         = 0;
        rst_n          = 1'b0;
        bus32.start    = 1'b0;
        bus32.dividend = '0;
        bus32.divisor  = '0;
        bus8.start     = 1'b0;
        bus8.dividend  = '0;
        bus8.divisor   = '0;
        last_q32       = '0;
        last_r32       = '0;
        last_q8        = '0;
        last_r8        = '0;

        repeat (3) @(negedge clk);
        check("rst_busy", 64'(bus32.busy), 64'd0);
        check("rst_done", 64'(bus32.done), 64'd0);
        check("rst_q", 64'(bus32.quotient), 64'd0);
        check("rst_r", 64'(bus32.remainder), 64'd0);
        check("rst_dbz", 64'(bus32.div_by_zero), 64'd0);
        check("rst8_busy", 64'(bus8.busy), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Vector table, issued back to back.
        for (int i = 0; i < 9; i++) begin
            op32(vecs[i], $sformatf("vec%0d", i));
        end

        // Start held high through RUN with changing operands: only the first is taken.
        e = '{32'd333, 32'd1, 1'b0, 33};
        bus32.start    = 1'b1;
        bus32.dividend = 32'd1000;
        bus32.divisor  = 32'd3;
        sb32.push_back(e);
        @(negedge clk);
        wait_check32("hold_first");
        bus32.dividend = 32'd77;
        bus32.divisor  = 32'd5;
        e = '{32'd15, 32'd2, 1'b0, 33};
        sb32.push_back(e);
        @(negedge clk);
        check("hold_next_accept", 64'(bus32.busy), 64'd1);
        bus32.start = 1'b0;
        wait_check32("hold_second");

        // Reset during RUN aborts without a done pulse.
        bus32.start    = 1'b1;
        bus32.dividend = 32'd500;
        bus32.divisor  = 32'd7;
        e = '{32'd71, 32'd3, 1'b0, 33};
        sb32.push_back(e);
        @(negedge clk);
        bus32.start = 1'b0;
        done_cnt = 0;
        repeat (9) begin
            if (bus32.done) done_cnt++;
            @(negedge clk);
        end
        check("abort_busy_before", 64'(bus32.busy), 64'd1);
        rst_n = 1'b0;
        @(negedge clk);
        sb32.delete();
        check("abort_busy", 64'(bus32.busy), 64'd0);
        check("abort_done", 64'(bus32.done), 64'd0);
        check("abort_q", 64'(bus32.quotient), 64'd0);
        check("abort_r", 64'(bus32.remainder), 64'd0);
        check("abort_dbz", 64'(bus32.div_by_zero), 64'd0);
        rst_n = 1'b1;
        repeat (40) begin
            if (bus32.done || bus32.busy) done_cnt++;
            @(negedge clk);
        end
        check("abort_no_done", 64'(done_cnt), 64'd0);
        last_q32 = '0;
        last_r32 = '0;
        v = '{32'd81, 32'd9, 32'd9, 32'd0, 1'b0};
        op32(v, "after_abort");

        // 8-bit instance: random operands against the arithmetic definition.
        for (int i = 0; i < 1000; i++) begin
            a8 = $urandom_range(0, 255);
            b8 = (i % 100 == 7) ? 0 : $urandom_range(0, 255);
            e.q   = (b8 == 0) ? 32'd255 : 32'(a8 / b8);
            e.r   = (b8 == 0) ? 32'(a8) : 32'(a8 % b8);
            e.z   = (b8 == 0);
            e.lat = (b8 == 0) ? 1 : 9;
            bus8.start    = 1'b1;
            bus8.dividend = a8[7:0];
            bus8.divisor  = b8[7:0];
            sb8.push_back(e);
            @(negedge clk);
            bus8.start = 1'b0;
            lat     = 1;
            held_ok = 1'b1;
            while (!bus8.done && lat < 30) begin
                if (bus8.quotient !== last_q8 || bus8.remainder !== last_r8) held_ok = 1'b0;
                @(negedge clk);
                lat++;
            end
            e = sb8.pop_front();
            check($sformatf("r8_%0d_done_seen", i), 64'(bus8.done), 64'd1);
            check($sformatf("r8_%0d_latency", i), 64'(lat), 64'(e.lat));
            check($sformatf("r8_%0d_held", i), 64'(held_ok), 64'd1);
            check($sformatf("r8_%0d_q(%0d/%0d)", i, a8, b8), 64'(bus8.quotient), 64'(e.q));
            check($sformatf("r8_%0d_r(%0d/%0d)", i, a8, b8), 64'(bus8.remainder), 64'(e.r));
            check($sformatf("r8_%0d_dbz", i), 64'(bus8.div_by_zero), 64'(e.z));
            last_q8 = e.q[7:0];
            last_r8 = e.r[7:0];
            gap = $urandom_range(1, 3);
            repeat (gap) @(negedge clk);
            check($sformatf("r8_%0d_idle_hold", i),
                  64'({bus8.quotient, bus8.remainder}), 64'({last_q8, last_r8}));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
